// File: rtl/branch_predictor.sv
// branch_predictor: tagged direct-mapped BTB with saturating direction
// counters and optional gshare indexing. Prediction is combinational from
// pc_F and registered state. Decode feeds back the resolved outcome, which
// updates the table, raises mispredict and supplies recover_pc.
// Saturating statistics counters are kept alongside.
//
// Update handshake: upd_valid marks a resolved branch or jump in decode.
// hold acts as the inverse of ready. An outcome is consumed only in a cycle
// with upd_valid=1, hold=0 and rst=0, and decode keeps it stable until then.
// So an outcome held across several stall cycles is applied exactly once.
module branch_predictor #(
  parameter int PC_W    = 10,
  parameter int IDX_W   = 4,
  parameter int CTR_W   = 2,
  parameter int HIST_EN = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [PC_W-1:0]   pc_F,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic              pred_hit,
  output logic [IDX_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic              upd_jump,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  input  logic [IDX_W-1:0]  upd_ghr,
  output logic              mispredict,
  output logic [PC_W-1:0]   recover_pc,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  // Table storage
  logic [N-1:0]      r_valid;
  logic [N-1:0]      r_jmp;
  logic [TAG_W-1:0]  r_tag    [N];
  logic [PC_W-1:0]   r_target [N];
  logic [CTR_W-1:0]  r_ctr    [N];

  // Global history and statistics
  logic [IDX_W-1:0]  r_ghr;
  logic [CNT_W-1:0]  r_branches;
  logic [CNT_W-1:0]  r_mispredicts;

  // Prediction-side wires
  logic [IDX_W-1:0]  w_ghr_use;
  logic [IDX_W-1:0]  w_pidx;
  logic              w_p_hit;

  // Update-side wires
  logic              w_ue;
  logic [IDX_W-1:0]  w_uidx;
  logic              w_u_hit;
  logic [CTR_W-1:0]  w_ctr_cur;
  logic [CTR_W-1:0]  w_ctr_inc;
  logic [CTR_W-1:0]  w_ctr_dec;
  logic              w_mis;

  // Bimodal mode ignores history entirely; the register stays at its reset 0.
  assign w_ghr_use = (HIST_EN != 0) ? r_ghr : '0;

  // Fetch-side lookup uses the live GHR.
  assign w_pidx  = pc_F[IDX_W-1:0] ^ w_ghr_use;
  assign w_p_hit = r_valid[w_pidx] & (r_tag[w_pidx] == pc_F[PC_W-1:IDX_W]);

  assign pred_hit    = w_p_hit;
  assign pred_taken  = w_p_hit & (r_jmp[w_pidx] | r_ctr[w_pidx][CTR_W-1]);
  assign pred_target = w_p_hit ? r_target[w_pidx] : '0;
  assign pred_ghr    = w_ghr_use;

  // Update side indexes with the GHR the prediction was made under, so the
  // entry trained is the one that produced the prediction.
  assign w_ue    = upd_valid & ~hold & ~rst;
  assign w_uidx  = upd_pc[IDX_W-1:0] ^ ((HIST_EN != 0) ? upd_ghr : '0);
  assign w_u_hit = r_valid[w_uidx] & (r_tag[w_uidx] == upd_pc[PC_W-1:IDX_W]);

  assign w_ctr_cur = r_ctr[w_uidx];
  assign w_ctr_inc = (w_ctr_cur == CTR_MAX) ? w_ctr_cur : w_ctr_cur + CTR_W'(1);
  assign w_ctr_dec = (w_ctr_cur == '0)      ? w_ctr_cur : w_ctr_cur - CTR_W'(1);

  // Direction and target are both checked; a wrong target only matters if taken.
  assign w_mis = w_ue & ((upd_taken != upd_pred_taken) |
                         (upd_taken & (upd_pred_target != upd_target)));

  assign mispredict = w_mis;
  // Fall-through wraps modulo 2^PC_W through the natural truncation of the add.
  assign recover_pc = w_ue ? (upd_taken ? upd_target : upd_pc + PC_W'(1)) : '0;

  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;

  // Table training: adjust the counter on a hit, allocate on a taken miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_jmp   <= '0;
      for (int i = 0; i < N; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (w_ue) begin
      if (w_u_hit) begin
        if (upd_jump) begin
          r_ctr[w_uidx] <= CTR_MAX;
          r_jmp[w_uidx] <= 1'b1;
        end else if (upd_taken) begin
          r_ctr[w_uidx] <= w_ctr_inc;
        end else begin
          r_ctr[w_uidx] <= w_ctr_dec;
        end
        if (upd_taken) begin
          r_target[w_uidx] <= upd_target;
        end
      end else if (upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= upd_pc[PC_W-1:IDX_W];
        r_target[w_uidx] <= upd_target;
        r_jmp[w_uidx]    <= upd_jump;
        r_ctr[w_uidx]    <= upd_jump ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  // Global history: shift in conditional outcomes only; jumps leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if ((HIST_EN != 0) && w_ue && !upd_jump) begin
      r_ghr <= (r_ghr << 1) | IDX_W'(upd_taken);
    end
  end

  // Statistics: count resolved branches and mispredicts, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (w_ue) begin
      if (!(&r_branches)) begin
        r_branches <= r_branches + CNT_W'(1);
      end
      if (w_mis && !(&r_mispredicts)) begin
        r_mispredicts <= r_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor. Two instances share one stimulus stream:
// dut0 is bimodal with default widths, dut1 is gshare with narrow 3-bit
// statistics. A behavioural model per instance predicts every output.
module tb_branch_predictor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hold;
  logic [9:0]  pc_F;
  logic        upd_valid;
  logic        upd_jump;
  logic [9:0]  upd_pc;
  logic        upd_taken;
  logic [9:0]  upd_target;
  logic        upd_pred_taken;
  logic [9:0]  upd_pred_target;
  logic [3:0]  upd_ghr;

  logic        p0_taken, p0_hit, p0_mis;
  logic [9:0]  p0_tgt, p0_rpc;
  logic [3:0]  p0_ghr;
  logic [15:0] s0_br, s0_mp;

  logic        p1_taken, p1_hit, p1_mis;
  logic [9:0]  p1_tgt, p1_rpc;
  logic [3:0]  p1_ghr;
  logic [2:0]  s1_br, s1_mp;

  branch_predictor #(.PC_W(10), .IDX_W(4), .CTR_W(2), .HIST_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .hold(hold), .pc_F(pc_F),
    .pred_taken(p0_taken), .pred_target(p0_tgt), .pred_hit(p0_hit), .pred_ghr(p0_ghr),
    .upd_valid(upd_valid), .upd_jump(upd_jump), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(p0_mis), .recover_pc(p0_rpc),
    .stat_branches(s0_br), .stat_mispredicts(s0_mp)
  );

  branch_predictor #(.PC_W(10), .IDX_W(4), .CTR_W(2), .HIST_EN(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .hold(hold), .pc_F(pc_F),
    .pred_taken(p1_taken), .pred_target(p1_tgt), .pred_hit(p1_hit), .pred_ghr(p1_ghr),
    .upd_valid(upd_valid), .upd_jump(upd_jump), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(p1_mis), .recover_pc(p1_rpc),
    .stat_branches(s1_br), .stat_mispredicts(s1_mp)
  );

  // ---------------- reference model ----------------
  // Per instance k: table of 16 entries, history and counters as plain ints.
  int m_valid [2][16];
  int m_tag   [2][16];
  int m_tgt   [2][16];
  int m_ctr   [2][16];
  int m_jmp   [2][16];
  int m_ghr   [2];
  int m_br    [2];
  int m_mp    [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_max(input int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  function automatic int hist_of(input int k, input int g);
    return (k == 1) ? g : 0;
  endfunction

  function automatic int exp_ue();
    return (upd_valid && !hold && !rst) ? 1 : 0;
  endfunction

  function automatic int exp_mis();
    if (exp_ue() == 0) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    if (upd_taken && (upd_pred_target != upd_target)) return 1;
    return 0;
  endfunction

  function automatic int exp_rpc();
    if (exp_ue() == 0) return 0;
    return upd_taken ? int'(upd_target) : ((int'(upd_pc) + 1) % 1024);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[k][i] = 0; m_tag[k][i] = 0; m_tgt[k][i] = 0;
        m_ctr[k][i] = 0;   m_jmp[k][i] = 0;
      end
      m_ghr[k] = 0; m_br[k] = 0; m_mp[k] = 0;
    end
  endtask

  // Compare every output of instance k against the model's current view.
  task automatic check_inst(input int k);
    int idx, hit, tk, tg, mis;
    idx = (int'(pc_F) % 16) ^ hist_of(k, m_ghr[k]);
    hit = (m_valid[k][idx] != 0 && m_tag[k][idx] == int'(pc_F) / 16) ? 1 : 0;
    tk  = (hit != 0 && (m_jmp[k][idx] != 0 || m_ctr[k][idx] >= 2)) ? 1 : 0;
    tg  = (hit != 0) ? m_tgt[k][idx] : 0;
    mis = exp_mis();
    if (k == 0) begin
      chk("d0_hit", 32'(p0_hit), 32'(hit));
      chk("d0_taken", 32'(p0_taken), 32'(tk));
      chk("d0_target", 32'(p0_tgt), 32'(tg));
      chk("d0_ghr", 32'(p0_ghr), 32'(0));
      chk("d0_mispredict", 32'(p0_mis), 32'(mis));
      chk("d0_recover", 32'(p0_rpc), 32'(exp_rpc()));
      chk("d0_branches", 32'(s0_br), 32'(m_br[0]));
      chk("d0_mispredicts", 32'(s0_mp), 32'(m_mp[0]));
    end else begin
      chk("d1_hit", 32'(p1_hit), 32'(hit));
      chk("d1_taken", 32'(p1_taken), 32'(tk));
      chk("d1_target", 32'(p1_tgt), 32'(tg));
      chk("d1_ghr", 32'(p1_ghr), 32'(m_ghr[1]));
      chk("d1_mispredict", 32'(p1_mis), 32'(mis));
      chk("d1_recover", 32'(p1_rpc), 32'(exp_rpc()));
      chk("d1_branches", 32'(s1_br), 32'(m_br[1]));
      chk("d1_mispredicts", 32'(s1_mp), 32'(m_mp[1]));
    end
  endtask

  // Apply the clock edge to the model using the inputs still being driven.
  task automatic model_edge();
    int idx, hit, mis;
    if (rst) begin
      model_clear();
      return;
    end
    if (exp_ue() == 0) return;
    mis = exp_mis();
    for (int k = 0; k < 2; k++) begin
      idx = (int'(upd_pc) % 16) ^ hist_of(k, int'(upd_ghr));
      hit = (m_valid[k][idx] != 0 && m_tag[k][idx] == int'(upd_pc) / 16) ? 1 : 0;
      if (hit != 0) begin
        if (upd_jump) begin
          m_ctr[k][idx] = 3; m_jmp[k][idx] = 1;
        end else if (upd_taken) begin
          m_ctr[k][idx] = (m_ctr[k][idx] < 3) ? m_ctr[k][idx] + 1 : 3;
        end else begin
          m_ctr[k][idx] = (m_ctr[k][idx] > 0) ? m_ctr[k][idx] - 1 : 0;
        end
        if (upd_taken) m_tgt[k][idx] = int'(upd_target);
      end else if (upd_taken) begin
        m_valid[k][idx] = 1;
        m_tag[k][idx]   = int'(upd_pc) / 16;
        m_tgt[k][idx]   = int'(upd_target);
        m_jmp[k][idx]   = upd_jump ? 1 : 0;
        m_ctr[k][idx]   = upd_jump ? 3 : 2;
      end
      if (k == 1 && !upd_jump) m_ghr[1] = ((m_ghr[1] * 2) + (upd_taken ? 1 : 0)) % 16;
      if (m_br[k] < cnt_max(k)) m_br[k]++;
      if (mis != 0 && m_mp[k] < cnt_max(k)) m_mp[k]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic drive(input logic h, input logic uv, input logic uj, input logic [9:0] upc,
                       input logic ut, input logic [9:0] utgt, input logic upt,
                       input logic [9:0] uptgt, input logic [3:0] ughr, input logic [9:0] pcf);
    hold = h; upd_valid = uv; upd_jump = uj; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    upd_ghr = ughr; pc_F = pcf;
    #1;
  endtask

  task automatic tick();
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h0, 10'h0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] pool [8];
  logic [9:0] r_upc, r_utgt, r_uptgt;
  logic       r_ut, r_uj, r_upt;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h0, 10'h0);
    @(posedge clk);
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0;

    // Reset state
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h0, 10'h005);
    chk("rst_hit", 32'(p0_hit), 32'd0);
    chk("rst_taken", 32'(p0_taken), 32'd0);
    chk("rst_target", 32'(p0_tgt), 32'd0);
    chk("rst_stats", 32'(s0_br) + 32'(s0_mp), 32'd0);
    tick();

    // Taken miss allocates weakly taken
    drive(0, 1, 0, 10'h005, 1, 10'h020, 0, 10'h000, 4'h0, 10'h005);
    chk("alloc_mispredict", 32'(p0_mis), 32'd1);
    chk("alloc_recover", 32'(p0_rpc), 32'h020);
    tick();
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h0, 10'h005);
    chk("alloc_hit", 32'(p0_hit), 32'd1);
    chk("alloc_taken", 32'(p0_taken), 32'd1);
    chk("alloc_target", 32'(p0_tgt), 32'h020);
    tick();

    // Three not-taken updates drive the counter to 0 and hold it there
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 10'h005, 0, 10'h000, (i == 0), 10'h020, 4'h0, 10'h005);
      chk("nt_recover", 32'(p0_rpc), 32'h006);
      chk("nt_mispredict", 32'(p0_mis), (i == 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("nt_pred_taken", 32'(p0_taken), 32'd0);
      tick();
    end

    // Jump at the top of the address space, then a not-taken branch there
    drive(0, 1, 1, 10'h3FF, 1, 10'h010, 0, 10'h000, 4'h0, 10'h3FF);
    chk("jmp_recover", 32'(p0_rpc), 32'h010);
    tick();
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h0, 10'h3FF);
    chk("jmp_taken", 32'(p0_taken), 32'd1);
    chk("jmp_target", 32'(p0_tgt), 32'h010);
    tick();
    drive(0, 1, 0, 10'h3FF, 0, 10'h000, 0, 10'h000, 4'h0, 10'h3FF);
    chk("wrap_recover", 32'(p0_rpc), 32'h000);
    chk("wrap_mispredict", 32'(p0_mis), 32'd0);
    tick();

    // Stall with a pending outcome, then release it
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 10'h007, 1, 10'h033, 0, 10'h000, 4'h0, 10'h007);
      chk("hold_mispredict", 32'(p0_mis), 32'd0);
      chk("hold_recover", 32'(p0_rpc), 32'd0);
      tick();
    end
    chk("hold_branches", 32'(s0_br), 32'd6);
    drive(0, 1, 0, 10'h007, 1, 10'h033, 0, 10'h000, 4'h0, 10'h007);
    tick();
    chk("release_branches", 32'(s0_br), 32'd7);
    chk("release_mispredicts", 32'(s0_mp), 32'd4);

    // Reset mid-operation with an update pending: nothing written
    rst = 1'b1;
    drive(0, 1, 0, 10'h00B, 1, 10'h044, 0, 10'h000, 4'h0, 10'h00B);
    chk("rst_upd_mispredict", 32'(p0_mis), 32'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h0, 10'h00B);
    chk("rst_upd_hit", 32'(p0_hit), 32'd0);
    tick();

    // Gshare: taken then not-taken leaves history 0b0010
    drive(0, 1, 0, 10'h001, 1, 10'h040, 1, 10'h040, 4'h0, 10'h000);
    tick();
    drive(0, 1, 0, 10'h002, 0, 10'h000, 0, 10'h000, 4'h1, 10'h000);
    tick();
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h2, 10'h001);
    chk("gs_ghr", 32'(p1_ghr), 32'h2);
    chk("gs_hit_other_idx", 32'(p1_hit), 32'd0);
    chk("bim_hit_same_pc", 32'(p0_hit), 32'd1);
    tick();
    drive(0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0, 4'h2, 10'h003);
    chk("gs_alias_hit", 32'(p1_hit), 32'd1);
    chk("gs_alias_target", 32'(p1_tgt), 32'h040);
    tick();

    // Statistics saturation on the narrow instance
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 10'h009, 1, 10'h050, 0, 10'h000, 4'h0, 10'h009);
      tick();
    end
    chk("sat_branches", 32'(s1_br), 32'd7);
    chk("sat_mispredicts", 32'(s1_mp), 32'd7);
    chk("wide_branches", 32'(s0_br), 32'd10);

    // Randomised traffic over a small PC pool so entries alias and retrain
    reset_pulse();
    pool[0] = 10'h005; pool[1] = 10'h015; pool[2] = 10'h3FF; pool[3] = 10'h0A3;
    pool[4] = 10'h013; pool[5] = 10'h200; pool[6] = 10'h3F0; pool[7] = 10'h001;
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      r_upc  = pool[$urandom_range(0, 7)];
      r_uj   = ($urandom_range(0, 6) == 0);
      r_ut   = r_uj ? 1'b1 : 1'($urandom_range(0, 1));
      r_utgt = 10'($urandom_range(0, 1023));
      r_upt  = 1'($urandom_range(0, 1));
      r_uptgt = ($urandom_range(0, 1) == 0) ? r_utgt : 10'($urandom_range(0, 1023));
      drive(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) != 0), r_uj, r_upc,
            r_ut, r_utgt, r_upt, r_uptgt, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? r_upc : pool[$urandom_range(0, 7)]);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
